// File: rtl/scan_chain_loader.sv
// Scan-chain configuration loader: shifts a CHAIN_LEN-bit image MSB-first into the chain, one bit per SHIFT_DIV clocks.
// Optional macro SCAN_CHAIN_READBACK_EN adds rd_image_o, the chain contents displaced by the last completed load.
module scan_chain_loader #(
  parameter int unsigned CHAIN_LEN = 92,
  parameter int unsigned SHIFT_DIV = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [CHAIN_LEN-1:0] image_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_valid_o,
  output logic                 scan_en_o,
  output logic                 scan_in_o,
  input  logic                 scan_out_i
`ifdef SCAN_CHAIN_READBACK_EN
  ,
  output logic [CHAIN_LEN-1:0] rd_image_o
`endif
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned DIV_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;

`ifdef SCAN_CHAIN_READBACK_EN
  logic [CHAIN_LEN-1:0] rb_q, rb_d;
  logic [CHAIN_LEN-1:0] rd_image_q, rd_image_d;
`else
  logic unused_scan_out;
  assign unused_scan_out = scan_out_i;
`endif

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      shreg_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
`ifdef SCAN_CHAIN_READBACK_EN
      rb_q        <= '0;
      rd_image_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      shreg_q     <= shreg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_valid_q <= cfg_valid_d;
      scan_en_q   <= scan_en_d;
      scan_in_q   <= scan_in_d;
`ifdef SCAN_CHAIN_READBACK_EN
      rb_q        <= rb_d;
      rd_image_q  <= rd_image_d;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    shreg_d     = shreg_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cfg_valid_d = cfg_valid_q;
    scan_en_d   = 1'b0;
    scan_in_d   = scan_in_q;
`ifdef SCAN_CHAIN_READBACK_EN
    // The chain tail is sampled on every edge the chain actually shifts
    rb_d        = scan_en_q ? {rb_q[CHAIN_LEN-2:0], scan_out_i} : rb_q;
    rd_image_d  = rd_image_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          shreg_d     = image_i;
          bit_cnt_d   = '0;
          div_cnt_d   = '0;
          cfg_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy_d = 1'b1;
        if (abort_i) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (bit_cnt_q == CNT_W'(CHAIN_LEN)) begin
          // Last bit was presented in the previous cycle and is clocked into the chain now
          done_d      = 1'b1;
          cfg_valid_d = 1'b1;
          state_d     = ST_DONE;
`ifdef SCAN_CHAIN_READBACK_EN
          rd_image_d  = rb_d;
`endif
        end else begin
          div_cnt_d = (div_cnt_q == DIV_W'(SHIFT_DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
          if (div_cnt_q == '0) begin
            scan_en_d = 1'b1;
            scan_in_d = shreg_q[CHAIN_LEN-1];
            shreg_d   = {shreg_q[CHAIN_LEN-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cfg_valid_o = cfg_valid_q;
  assign scan_en_o   = scan_en_q;
  assign scan_in_o   = scan_in_q;
`ifdef SCAN_CHAIN_READBACK_EN
  assign rd_image_o  = rd_image_q;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Scoreboard bench for scan_chain_loader: stimulus pushes expected pulses/done/flag snapshots, a monitor pops and compares.
module tb_scan_chain_loader;

  localparam int N  = 92;
  localparam int D1 = 1;
  localparam int D3 = 3;

  typedef struct {int cyc; logic b;} pulse_t;
  typedef struct {int cyc; logic [N-1:0] img; logic [N-1:0] rd;} done_t;
  typedef struct {int cyc; logic busy; logic cfg; logic sen; logic dn; logic sin_chk; logic sin;} spot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic         reset, start, abort, busy, done, cfg_valid, scan_en, scan_in, scan_out;
  logic [N-1:0] image;
  logic         reset3, start3, abort3, busy3, done3, cfg_valid3, scan_en3, scan_in3;
  logic         scan_out3 = 1'b0;
  logic [N-1:0] image3;
`ifdef SCAN_CHAIN_READBACK_EN
  logic [N-1:0] rd_image, rd_image3;
`endif

  scan_chain_loader #(.CHAIN_LEN(N), .SHIFT_DIV(D1)) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .image_i(image), .abort_i(abort),
    .busy_o(busy), .done_o(done), .cfg_valid_o(cfg_valid), .scan_en_o(scan_en),
    .scan_in_o(scan_in), .scan_out_i(scan_out)
`ifdef SCAN_CHAIN_READBACK_EN
    , .rd_image_o(rd_image)
`endif
  );

  scan_chain_loader #(.CHAIN_LEN(N), .SHIFT_DIV(D3)) u_dut3 (
    .clk_i(clk), .reset_i(reset3), .start_i(start3), .image_i(image3), .abort_i(abort3),
    .busy_o(busy3), .done_o(done3), .cfg_valid_o(cfg_valid3), .scan_en_o(scan_en3),
    .scan_in_o(scan_in3), .scan_out_i(scan_out3)
`ifdef SCAN_CHAIN_READBACK_EN
    , .rd_image_o(rd_image3)
`endif
  );

  // Behavioural scan chain attached to the main instance
  logic [N-1:0] chain_m    = 92'h0123456789ABCDEF0246ACE;
  logic [N-1:0] resident_m = 92'h0123456789ABCDEF0246ACE;
  always @(posedge clk) if (scan_en === 1'b1) chain_m <= {chain_m[N-2:0], scan_in};
  assign scan_out = chain_m[N-1];

  pulse_t pulse_q[$];
  done_t  done_q[$];
  spot_t  spot_q[$];

  task automatic check_b(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_i(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_v(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void push_spot(input int c, input logic b, input logic cf, input logic se,
                                    input logic dn, input logic sc, input logic si);
    spot_t s;
    s = '{c, b, cf, se, dn, sc, si};
    spot_q.push_back(s);
  endfunction

  function automatic logic [N-1:0] rand_img();
    return N'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Reference: load accepted on edge a, nk bits leave the image MSB-first; mode 0 complete, 1 abort, 2 reset
  function automatic void expect_load(input logic [N-1:0] img, input int a, input int nk, input int mode);
    pulse_t p;
    done_t  d;
    int     dc;
    push_spot(a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < nk; k++) begin
      p = '{a + 1 + k * D1, img[N-1-k]};
      pulse_q.push_back(p);
    end
    if (mode == 0) begin
      dc = a + 2 + (N - 1) * D1;
      d  = '{dc, img, resident_m};
      done_q.push_back(d);
      push_spot(dc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end else if (mode == 1) begin
      push_spot(a + 1 + (nk - 1) * D1 + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    resident_m = (resident_m << nk) | (img >> (N - nk));
  endfunction

  // Monitor: pops expectations whenever the DUT presents a pulse, a done, or a snapshot cycle arrives
  int     pulse_cnt = 0;
  pulse_t mp;
  done_t  md;
  spot_t  ms;
  always @(posedge clk) begin
    #1;
    while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
      mp = pulse_q.pop_front();
      check_i("missed_pulse", cyc, mp.cyc);
    end
    if (scan_en === 1'b1) begin
      pulse_cnt++;
      if (pulse_q.size() == 0) check_i("unexpected_pulse", cyc, -1);
      else begin
        mp = pulse_q.pop_front();
        check_i("pulse_cycle", cyc, mp.cyc);
        check_b("scan_in_bit", scan_in, mp.b);
      end
    end
    while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
      md = done_q.pop_front();
      check_i("missed_done", cyc, md.cyc);
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) check_i("unexpected_done", cyc, -1);
      else begin
        md = done_q.pop_front();
        check_i("done_cycle", cyc, md.cyc);
        check_b("cfg_valid_at_done", cfg_valid, 1'b1);
        check_v("chain_contents", chain_m, md.img);
`ifdef SCAN_CHAIN_READBACK_EN
        check_v("rd_image", rd_image, md.rd);
`endif
      end
    end
    while (spot_q.size() > 0 && spot_q[0].cyc <= cyc) begin
      ms = spot_q.pop_front();
      check_i("snapshot_cycle", cyc, ms.cyc);
      check_b("busy", busy, ms.busy);
      check_b("cfg_valid", cfg_valid, ms.cfg);
      check_b("scan_en", scan_en, ms.sen);
      check_b("done", done, ms.dn);
      if (ms.sin_chk) check_b("scan_in_reset", scan_in, ms.sin);
    end
  end

  task automatic load(input logic [N-1:0] img, input int abort_j, input bit abort_with_start);
    int a, x;
    @(negedge clk);
    start = 1'b1; image = img; abort = abort_with_start; a = cyc + 1;
    expect_load(img, a, (abort_j > 0) ? abort_j : N, (abort_j > 0) ? 1 : 0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    if (abort_j > 0) begin
      x = a + 1 + (abort_j - 1) * D1 + 1;
      while (cyc < x - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end else begin
      while (cyc < a + 2 + (N - 1) * D1 + 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic held_start(input logic [N-1:0] img);
    int a1, a2, d2, p0;
    @(negedge clk);
    p0 = pulse_cnt;
    start = 1'b1; image = img; a1 = cyc + 1;
    a2 = a1 + 2 + (N - 1) * D1 + 2;
    d2 = a2 + 2 + (N - 1) * D1;
    expect_load(img, a1, N, 0);
    expect_load(img, a2, N, 0);
    while (cyc < a2 + 5) @(negedge clk);
    start = 1'b0;
    while (cyc < d2 + 2) @(negedge clk);
    check_i("held_start_pulses", pulse_cnt - p0, 2 * N);
  endtask

  task automatic reset_mid(input logic [N-1:0] img, input int nk);
    int a;
    @(negedge clk);
    start = 1'b1; image = img; a = cyc + 1;
    expect_load(img, a, nk, 2);
    @(negedge clk);
    start = 1'b0;
    while (cyc < a + nk * D1) @(negedge clk);
    reset = 1'b1;
    push_spot(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Slow-shift instance: pulse spacing, bit order, scan_in stability and done latency
  bit           dut3_fin = 1'b0;
  int           a3, k3, stable_err, done3_cyc;
  logic         last3;
  logic [N-1:0] img3;
  initial begin
    reset3 = 1'b1; start3 = 1'b0; abort3 = 1'b0; image3 = '0;
    img3 = rand_img();
    k3 = 0; stable_err = 0; done3_cyc = -1; last3 = 1'b0;
    repeat (3) @(negedge clk);
    reset3 = 1'b0;
    @(negedge clk);
    start3 = 1'b1; image3 = img3; a3 = cyc + 1;
    @(negedge clk);
    start3 = 1'b0;
    for (int i = 0; i < 400 && done3_cyc < 0; i++) begin
      @(posedge clk);
      #1;
      if (scan_en3 === 1'b1) begin
        check_i("div3_pulse_cycle", cyc, a3 + 1 + k3 * D3);
        if (k3 < N) check_b("div3_scan_in", scan_in3, img3[N-1-k3]);
        last3 = scan_in3;
        k3++;
      end else if (k3 > 0 && scan_in3 !== last3) begin
        stable_err++;
      end
      if (done3 === 1'b1) begin
        done3_cyc = cyc;
        check_b("div3_cfg_valid", cfg_valid3, 1'b1);
`ifdef SCAN_CHAIN_READBACK_EN
        check_v("div3_rd_image", rd_image3, '0);
`endif
      end
    end
    check_i("div3_done_cycle", done3_cyc, a3 + 2 + (N - 1) * D3);
    check_i("div3_pulse_count", k3, N);
    check_i("div3_scan_in_stable", stable_err, 0);
    dut3_fin = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  logic [N-1:0] alt;
  logic [N-1:0] ones;
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; image = '0;
    repeat (3) @(negedge clk);
    check_b("reset_busy", busy, 1'b0);
    check_b("reset_done", done, 1'b0);
    check_b("reset_cfg_valid", cfg_valid, 1'b0);
    check_b("reset_scan_en", scan_en, 1'b0);
    check_b("reset_scan_in", scan_in, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    alt  = {23{4'hA}};
    ones = '1;
    load(alt, 0, 1'b0);
    load(ones, 0, 1'b0);
    load(N'(1), 0, 1'b0);
    load(rand_img(), 40, 1'b0);
    load(rand_img(), N, 1'b0);
    held_start(rand_img());
    reset_mid(rand_img(), 50);
    load(rand_img(), 0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      int gap, aj;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        abort = 1'($urandom_range(0, 1));
      end
      aj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N)) : 0;
      load(rand_img(), aj, 1'($urandom_range(0, 1)));
    end

    for (int w = 0; w < 1000 && !dut3_fin; w++) @(negedge clk);
    check_b("div3_finished", dut3_fin, 1'b1);
    repeat (5) @(negedge clk);
    check_i("pulse_queue_drained", pulse_q.size(), 0);
    check_i("done_queue_drained", done_q.size(), 0);
    check_i("snapshot_queue_drained", spot_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
